// File: rtl/branch_resolve_bht.sv
// Branch resolution, saturating-counter BHT training and registered mispredict flush/redirect.
// Optional BRANCH_STATS_EN builds saturating branch/mispredict counters; otherwise the stat ports read 0.
module branch_resolve_bht #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  pred_taken,
  input  logic                  res_valid,
  input  logic [ADDR_WIDTH-1:0] res_pc,
  input  logic [2:0]            res_fun3,
  input  logic [DATA_WIDTH-1:0] res_alu_res,
  input  logic                  res_alu_no_zero,
  input  logic                  res_pred_taken,
  input  logic [ADDR_WIDTH-1:0] res_target,
  output logic                  branch_res,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  // Weakly not-taken: MSB clear, remaining bits set (0 for a 1-bit counter).
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [CNT_WIDTH-1:0]  r_bht [BHT_DEPTH];
  logic                  r_flush;
  logic [ADDR_WIDTH-1:0] r_redirect;

  logic [IDX_W-1:0]      w_pred_idx;
  logic [IDX_W-1:0]      w_res_idx;
  logic                  w_legal;
  logic                  w_taken;
  logic                  w_upd;
  logic                  w_mispred;
  logic [CNT_WIDTH-1:0]  w_cnt_cur;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  w_unused;

  assign w_pred_idx = pred_pc[IDX_W+1:2];
  assign w_res_idx  = res_pc[IDX_W+1:2];
  assign pred_taken = r_bht[w_pred_idx][CNT_WIDTH-1];
  assign w_unused   = &{1'b0, pred_pc[ADDR_WIDTH-1:IDX_W+2], pred_pc[1:0],
                        res_pc[ADDR_WIDTH-1:IDX_W+2], res_pc[1:0],
                        res_alu_res[DATA_WIDTH-1:1]};

  // Outcome decode from funct3 and the ALU compare flags.
  always_comb begin
    w_legal = 1'b1;
    w_taken = 1'b0;
    case (res_fun3)
      3'b000:          w_taken = ~res_alu_no_zero;
      3'b001:          w_taken = res_alu_no_zero;
      3'b100, 3'b110:  w_taken = res_alu_res[0];
      3'b101, 3'b111:  w_taken = ~res_alu_res[0];
      default:         w_legal = 1'b0;
    endcase
  end

  assign w_upd      = res_valid & w_legal;
  assign branch_res = w_upd & w_taken;
  assign w_mispred  = w_upd & (branch_res != res_pred_taken);

  // Saturating counter step for the resolving entry.
  always_comb begin
    w_cnt_cur  = r_bht[w_res_idx];
    w_cnt_next = w_cnt_cur;
    if (branch_res) begin
      if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + CNT_WIDTH'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_INIT;
      r_flush    <= 1'b0;
      r_redirect <= '0;
    end else begin
      if (w_upd) r_bht[w_res_idx] <= w_cnt_next;
      r_flush <= w_mispred;
      if (w_mispred) r_redirect <= branch_res ? res_target : res_pc + ADDR_WIDTH'(4);
    end
  end

  assign flush       = r_flush;
  assign redirect_pc = r_redirect;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (w_upd && r_stat_br != 32'hFFFF_FFFF) r_stat_br <= r_stat_br + 32'd1;
      if (w_mispred && r_stat_mp != 32'hFFFF_FFFF) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule
